// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter sharing one single-port on-chip RAM (1-cycle read latency).
// Optional master bus locking is enabled by defining ONCHIP_ARB_LOCK_EN.
module onchip_mem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 12800,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
`ifdef ONCHIP_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [ERR_W-1:0]      err_count
);

  logic             last_grant_q, last_grant_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             rd_oor_q, rd_oor_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
`ifdef ONCHIP_ARB_LOCK_EN
  logic             locked_q, locked_d;
  logic             lock_owner_q, lock_owner_d;
  logic             gnt_lock;
`endif

  logic              req0, req1, elig0, elig1;
  logic              grant_valid, gnt, gnt_write, in_range;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] rd_data;

  // Grant decision and command mux; a write beats a simultaneous read from the same master.
  always_comb begin
    req0  = m0_read | m0_write;
    req1  = m1_read | m1_write;
    elig0 = req0;
    elig1 = req1;
`ifdef ONCHIP_ARB_LOCK_EN
    if (locked_q) begin
      elig0 = req0 & ~lock_owner_q;
      elig1 = req1 & lock_owner_q;
    end
    gnt_lock = 1'b0;
`endif
    grant_valid = reset_n & (elig0 | elig1);
    gnt         = (elig0 & elig1) ? ~last_grant_q : elig1;
    gnt_addr    = gnt ? m1_address : m0_address;
    gnt_write   = gnt ? m1_write : m0_write;
    in_range    = 32'(gnt_addr) < DEPTH;
`ifdef ONCHIP_ARB_LOCK_EN
    gnt_lock    = gnt ? m1_lock : m0_lock;
`endif

    m0_waitrequest = ~reset_n | (req0 & ~(grant_valid & ~gnt));
    m1_waitrequest = ~reset_n | (req1 & ~(grant_valid & gnt));

    mem_address    = gnt_addr;
    mem_byteenable = gnt ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt ? m1_writedata : m0_writedata;
    mem_chipselect = grant_valid & in_range;
    mem_write      = mem_chipselect & gnt_write;
    mem_clken      = 1'b1;

    // Out-of-range reads still complete, returning zero.
    m0_readdatavalid = rd_pend_q & ~rd_owner_q;
    m1_readdatavalid = rd_pend_q & rd_owner_q;
    rd_data          = rd_oor_q ? '0 : mem_readdata;
    m0_readdata      = m0_readdatavalid ? rd_data : '0;
    m1_readdata      = m1_readdatavalid ? rd_data : '0;
    err_count        = err_count_q;
  end

  // Next-state: round-robin pointer, read-pending tracker, saturating error counter.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    rd_oor_d     = rd_oor_q;
    err_count_d  = err_count_q;
`ifdef ONCHIP_ARB_LOCK_EN
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
`endif
    if (grant_valid) begin
      last_grant_d = gnt;
      if (!gnt_write) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = gnt;
        rd_oor_d   = ~in_range;
      end
      if (!in_range && (err_count_q != '1)) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
`ifdef ONCHIP_ARB_LOCK_EN
      // Only the lock owner can be granted while locked, so this both sets and releases.
      locked_d     = gnt_lock;
      lock_owner_d = gnt;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oor_q     <= 1'b0;
      err_count_q  <= '0;
`ifdef ONCHIP_ARB_LOCK_EN
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      err_count_q  <= err_count_d;
`ifdef ONCHIP_ARB_LOCK_EN
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter that shares one single-port on-chip RAM (32-bit, 12800 words, 14-bit word address) between two Avalon-MM masters, e.g. the Nios II data master and a DMA engine.
- Muxes one command per cycle onto the RAM port and tracks the 1-cycle read latency, routing read data back to the issuing master with readdatavalid.
- Drops out-of-range accesses and counts them.

Parameters:
- DATA_W, 32, data width in bits; byteenable width is DATA_W/8.
- ADDR_W, 14, word address width.
- DEPTH, 12800, number of implemented words; addresses >= DEPTH are out of range.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- mN_address  in  ADDR_W  master N word address (N = 0, 1; likewise for all mN_ ports).
- mN_byteenable  in  DATA_W/8  master N byte enables.
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request.
- mN_writedata  in  DATA_W  master N write data.
- mN_waitrequest  out  1  master N stall.
- mN_readdata  out  DATA_W  master N read data.
- mN_readdatavalid  out  1  master N read data valid.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable, tied to 1.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the address edge.
- err_count  out  ERR_W  saturating count of out-of-range accesses.

Behaviour:
- Interface: one clock domain (clk). Reset is asynchronous and active-low (reset_n).
- Request: reqN = mN_read | mN_write. If mN_read and mN_write are both high, the write wins and the read is ignored.
- Registers: last_grant (1 bit), rd_pend (1 bit), rd_owner (1 bit), rd_oor (1 bit), err_count.
- Reset values: last_grant = 1, so master 0 wins the first contention. rd_pend = 0, err_count = 0.
- Outputs while reset_n is low: mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0, mem_chipselect = 0, mem_write = 0.
- Grant is combinational, decided each cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: the master != last_grant is granted.
  - last_grant updates to the granted master at the clock edge.
- Granted master: mN_waitrequest = 0 and its command is accepted at the edge. Non-granted requester: mN_waitrequest = 1.
- Non-requesting master: mN_waitrequest = 0 (Avalon don't-care; held low).
- Memory side:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_chipselect = grant_valid & in_range.
  - mem_write = mem_chipselect & granted write.
- in_range = (address < DEPTH).
- Out-of-range write: no RAM access; err_count += 1 (saturates at 2^ERR_W - 1).
- Out-of-range read: no RAM access; err_count += 1; readdatavalid still returned with data 0.
- Read latency: exactly 1 cycle. An accepted read sets rd_pend = 1, rd_owner = N and rd_oor at the edge.
  - The following cycle: m[rd_owner]_readdatavalid = 1 and readdata = rd_oor ? 0 : mem_readdata.
  - The other master's readdata = 0.
- Throughput: one accepted transfer per cycle, back-to-back. A read accepted in cycle k and any transfer accepted in cycle k+1 are both legal.
- Both masters requesting continuously: grants alternate 0,1,0,1.
- Reset asserted mid-operation: pending read is discarded; no readdatavalid after reset_n deasserts.

Optional Feature:
- Macro: ONCHIP_ARB_LOCK_EN.
- Defined: adds ports m0_lock and m1_lock (in, 1).
  - A transfer accepted with mN_lock = 1 sets locked = 1 and lock_owner = N.
  - While locked, only lock_owner can be granted; the other master sees waitrequest = 1.
  - locked clears at the edge where lock_owner has a transfer accepted with mN_lock = 0.
  - Reset clears locked.
- Undefined: no lock ports; pure round-robin.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 5 with byteenable 0xF, then reads addr 5 -> m0_readdatavalid one cycle after acceptance with readdata 0xDEADBEEF.
- m0 and m1 both read continuously for 8 cycles -> grants 0,1,0,1,...; each master receives 4 readdatavalid pulses, 1-cycle latency each.
- m1 writes 0x11223344 to addr 7 with byteenable 0x3, after a prior write of 0xFFFFFFFF -> read of addr 7 returns 0xFFFF3344.
- m0 reads addr 12800 and writes addr 16383 -> no mem_chipselect; read returns 0 with valid; err_count = 2. After 300 out-of-range accesses, err_count = 255.
- Read accepted, then reset_n pulsed low in the next cycle -> no readdatavalid; all outputs at reset values.
- (ONCHIP_ARB_LOCK_EN) m0 issues 3 locked writes while m1 requests -> m1 waitrequest = 1 until m0's unlocked transfer; m1 is granted the following cycle.
